// File: rtl/error_report_uart_tx_pkg.sv
// Shared types and constants for the error-report frame transmitter.
package error_report_uart_tx_pkg;

   // Frame FSM states
   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SEND,
      ACK,
      WAIT_RELEASE
   } frame_state_t;

   localparam int         FRAME_BYTES         = 34;
   localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

   // Eight 32-bit per-output error sums, shared with the processing FSM
   typedef logic [7:0][31:0] error_sums_t;

   // Payload byte p (0..31): sums[p/4], big-endian within each word
   function automatic logic [7:0] payload_byte(input error_sums_t sums, input logic [4:0] p);
      logic [31:0] w_word;
      w_word = sums[p[4:2]];
      case (p[1:0])
         2'd0:    return w_word[31:24];
         2'd1:    return w_word[23:16];
         2'd2:    return w_word[15:8];
         default: return w_word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/error_report_uart_tx_uart_tx_byte.sv
// 8N1 byte transmitter. A new iStart is accepted while idle or in the
// final cycle of the stop bit (oByteDone), which gives gapless bytes.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       iClock,
   input  logic       iReset,
   input  logic       iStart,
   input  logic [7:0] iData,
   output logic       oTx,
   output logic       oByteDone,
   output logic       oReady
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CLK_LOAD = CW'(CLKS_PER_BIT - 1);

   logic          r_active;
   logic          r_tx;
   logic [8:0]    r_shift;   // remaining data bits with the stop bit on top
   logic [3:0]    r_bit;     // 0 = start, 1..8 = data, 9 = stop
   logic [CW-1:0] r_clk;     // counts CLK_LOAD down to 0 within one bit
   logic          w_bit_end;
   logic          w_byte_done;

   assign w_bit_end   = (r_clk == '0);
   assign w_byte_done = r_active && w_bit_end && (r_bit == 4'd9);

   assign oTx       = r_tx;
   assign oByteDone = w_byte_done;
   assign oReady    = !r_active || w_byte_done;

   // Bit timing, shifting and line drive
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_active <= 1'b0;
         r_tx     <= 1'b1;
         r_shift  <= '1;
         r_bit    <= '0;
         r_clk    <= '0;
      end else if (iStart && (!r_active || w_byte_done)) begin
         r_active <= 1'b1;
         r_tx     <= 1'b0;
         r_shift  <= {1'b1, iData};
         r_bit    <= '0;
         r_clk    <= CLK_LOAD;
      end else if (r_active) begin
         if (w_bit_end) begin
            if (r_bit == 4'd9) begin
               r_active <= 1'b0;
               r_tx     <= 1'b1;
            end else begin
               r_tx    <= r_shift[0];
               r_shift <= {1'b1, r_shift[8:1]};
               r_bit   <= r_bit + 4'd1;
               r_clk   <= CLK_LOAD;
            end
         end else begin
            r_clk <= r_clk - 1'b1;
         end
      end
   end

endmodule

// File: rtl/error_report_uart_tx.sv
// Latches the eight error sums on done and sends them as a 34-byte UART
// frame (header, 32 big-endian payload bytes, XOR checksum), then pulses
// the done feedback to release the processing FSM.
module error_report_uart_tx
   import error_report_uart_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
   input  logic        iClock,
   input  logic        iReset,
   input  error_sums_t iErrorSums,
   input  logic        iDoneProcessing,
   output logic        oDoneFeedback,
   output logic        oTx,
   output logic        oBusy,
   output logic [15:0] oFrameCount
);

   localparam logic [5:0] LAST_INDEX = 6'(FRAME_BYTES - 1);

   frame_state_t r_state;
   frame_state_t w_state_next;
   error_sums_t  r_sums;
   logic [5:0]   r_index;        // byte currently on the line
   logic [7:0]   r_checksum;
   logic         r_kick;         // requests the header start on the first SEND cycle
   logic [15:0]  r_frame_count;
   logic [5:0]   w_next_index;
   logic [7:0]   w_byte_data;
   logic         w_start;
   logic         w_byte_done;
   logic         w_uart_ready;
   logic         w_busy;
   logic         w_done_fb;

   assign w_next_index = r_kick ? 6'd0 : (r_index + 6'd1);
   assign w_start      = (r_state == SEND) && w_uart_ready
                         && (r_kick || (w_byte_done && (r_index != LAST_INDEX)));

   assign oDoneFeedback = w_done_fb;
   assign oBusy         = w_busy;
   assign oFrameCount   = r_frame_count;

   // Byte mux: header, payload from the frozen sums, or the checksum
   always_comb begin
      w_byte_data = HEADER_BYTE;
      if (w_next_index == LAST_INDEX) begin
         w_byte_data = r_checksum;
      end else if (w_next_index != 6'd0) begin
         w_byte_data = payload_byte(r_sums, 5'(w_next_index - 6'd1));
      end
   end

   // Frame state register
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b1;
      w_done_fb    = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (iDoneProcessing) w_state_next = LATCH;
         end
         LATCH:        w_state_next = SEND;
         SEND:         if (w_byte_done && (r_index == LAST_INDEX)) w_state_next = ACK;
         ACK: begin
            w_done_fb    = 1'b1;
            w_state_next = WAIT_RELEASE;
         end
         WAIT_RELEASE: if (!iDoneProcessing) w_state_next = IDLE;
         default:      w_state_next = IDLE;
      endcase
   end

   // Sum latch, byte index, running checksum and frame counter
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_sums        <= '0;
         r_index       <= '0;
         r_checksum    <= '0;
         r_kick        <= 1'b0;
         r_frame_count <= '0;
      end else begin
         if ((r_state == IDLE) && iDoneProcessing) begin
            r_sums <= iErrorSums;
         end
         if (r_state == LATCH) begin
            r_index    <= '0;
            r_checksum <= '0;
            r_kick     <= 1'b1;
         end else if (w_start) begin
            r_kick  <= 1'b0;
            r_index <= w_next_index;
            if ((w_next_index != 6'd0) && (w_next_index != LAST_INDEX)) begin
               r_checksum <= r_checksum ^ w_byte_data;
            end
         end
         if (r_state == ACK) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .iClock   (iClock),
      .iReset   (iReset),
      .iStart   (w_start),
      .iData    (w_byte_data),
      .oTx      (oTx),
      .oByteDone(w_byte_done),
      .oReady   (w_uart_ready)
   );

endmodule
